// File: rtl/delay_line_align_ctrl_pkg.sv
// Shared types, default sizing and the vote helper for the delay-line alignment controllers.
package delay_line_align_pkg;

  localparam int unsigned TAP_W_DEF         = 32'd8;
  localparam int unsigned MAX_TAPS_DEF      = 32'd128;
  localparam int unsigned SETTLE_CYCLES_DEF = 32'd8;
  localparam int unsigned VOTE_SAMPLES_DEF  = 32'd4;
  localparam int unsigned SWEEP_STEP_CYCLES = 32'd2 + SETTLE_CYCLES_DEF + VOTE_SAMPLES_DEF;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD      = 4'd1,
    ST_SETTLE    = 4'd2,
    ST_SAMPLE    = 4'd3,
    ST_EVAL      = 4'd4,
    ST_STEP      = 4'd5,
    ST_DONE      = 4'd6,
    ST_FAIL_LOAD = 4'd7,
    ST_FAIL      = 4'd8
  } align_state_e;

  // Strict majority: a tie votes 0.
  function automatic logic majority(input int unsigned ones, input int unsigned n);
    return ((ones * 32'd2) > n);
  endfunction

endpackage

// File: rtl/delay_line_align_ctrl_if.sv
// Control/status bundle between the alignment controller and the delay stage.
interface delay_line_align_if
  import delay_line_align_pkg::*;
#(
  parameter int unsigned TAP_W = TAP_W_DEF
);
  logic             align_start;
  logic             phase_in;
  logic             delay_line_out_of_range;
  logic             delay_line_load;
  logic             delay_line_move;
  logic             delay_line_dir;
  logic             busy;
  logic             align_done;
  logic             align_fail;
  logic [TAP_W-1:0] edge_tap;

  modport master (
    input  align_start, phase_in, delay_line_out_of_range,
    output delay_line_load, delay_line_move, delay_line_dir,
           busy, align_done, align_fail, edge_tap
  );

  modport slave (
    output align_start, phase_in, delay_line_out_of_range,
    input  delay_line_load, delay_line_move, delay_line_dir,
           busy, align_done, align_fail, edge_tap
  );
endinterface

// File: rtl/delay_line_align_ctrl_phase_vote.sv
// Accumulates VOTE_SAMPLES consecutive phase bits after a start pulse and
// presents the majority vote with a one-cycle done pulse.
module phase_vote_accum
  import delay_line_align_pkg::*;
#(
  parameter  int unsigned VOTE_SAMPLES = VOTE_SAMPLES_DEF,
  localparam int unsigned CNT_W        = $clog2(VOTE_SAMPLES + 32'd1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_phase,
  output logic [CNT_W-1:0] o_sample_cnt,
  output logic [CNT_W-1:0] o_ones_cnt,
  output logic             o_done,
  output logic             o_vote
);

  logic             r_armed;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_ones_cnt;
  logic             r_done;
  logic             r_vote;
  logic [CNT_W-1:0] w_ones_next;
  logic             w_last;

  assign w_ones_next = r_ones_cnt + CNT_W'(i_phase);
  assign w_last      = (r_sample_cnt == CNT_W'(VOTE_SAMPLES - 32'd1));

  // Sample counter holds at N-1 after the window so the caller can see the last sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_armed      <= 1'b0;
      r_sample_cnt <= '0;
      r_ones_cnt   <= '0;
      r_done       <= 1'b0;
      r_vote       <= 1'b0;
    end else if (i_start) begin
      r_armed      <= 1'b1;
      r_sample_cnt <= '0;
      r_ones_cnt   <= '0;
      r_done       <= 1'b0;
      r_vote       <= 1'b0;
    end else if (r_armed) begin
      r_ones_cnt <= w_ones_next;
      if (w_last) begin
        r_armed <= 1'b0;
        r_done  <= 1'b1;
        r_vote  <= majority(32'(w_ones_next), VOTE_SAMPLES);
      end else begin
        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
        r_done       <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_sample_cnt = r_sample_cnt;
  assign o_ones_cnt   = r_ones_cnt;
  assign o_done       = r_done;
  assign o_vote       = r_vote;

endmodule

// File: rtl/delay_line_align_ctrl.sv
// Sweeps the delay line upward one tap at a time and stops at the first 0->1
// transition of the majority-voted phase detector, reporting DONE or FAIL.
module delay_line_align_ctrl
  import delay_line_align_pkg::*;
#(
  parameter int unsigned TAP_W         = TAP_W_DEF,
  parameter int unsigned MAX_TAPS      = MAX_TAPS_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned VOTE_SAMPLES  = VOTE_SAMPLES_DEF
) (
  input logic               i_sclk,
  input logic               i_reset,
  delay_line_align_if.master bus
);

  localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 32'd1);
  localparam int unsigned VOTE_W = $clog2(VOTE_SAMPLES + 32'd1);

  align_state_e      r_state;
  align_state_e      w_next_state;
  logic [SET_W-1:0]  r_settle_cnt;
  logic [TAP_W-1:0]  r_tap_cnt;
  logic              r_prev_valid;
  logic              r_prev_vote;
  logic              r_oor_seen;
  logic              r_load;
  logic              r_move;
  logic              r_dir;
  logic              r_busy;
  logic              r_done;
  logic              r_fail;

  logic              w_settle_last;
  logic              w_sample_last;
  logic              w_tap_last;
  logic              w_acc_start;
  logic [VOTE_W-1:0] w_sample_cnt;
  logic [VOTE_W-1:0] w_unused_ones_cnt;
  logic              w_acc_done;
  logic              w_acc_vote;

  assign w_settle_last = (r_settle_cnt == SET_W'(SETTLE_CYCLES - 32'd1));
  assign w_sample_last = (w_sample_cnt == VOTE_W'(VOTE_SAMPLES - 32'd1));
  assign w_tap_last    = (r_tap_cnt == TAP_W'(MAX_TAPS - 32'd1));
  assign w_acc_start   = (r_state == ST_SETTLE) && w_settle_last;

  phase_vote_accum #(
    .VOTE_SAMPLES (VOTE_SAMPLES)
  ) u_vote (
    .i_clk        (i_sclk),
    .i_rst        (i_reset),
    .i_start      (w_acc_start),
    .i_phase      (bus.phase_in),
    .o_sample_cnt (w_sample_cnt),
    .o_ones_cnt   (w_unused_ones_cnt),
    .o_done       (w_acc_done),
    .o_vote       (w_acc_vote)
  );

  // Next-state decode; EVAL priority is edge found, then out-of-range/limit, then step.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (bus.align_start) w_next_state = ST_LOAD;
        else                 w_next_state = r_state;
      end
      ST_LOAD:   w_next_state = ST_SETTLE;
      ST_SETTLE: begin
        if (w_settle_last) w_next_state = ST_SAMPLE;
        else               w_next_state = ST_SETTLE;
      end
      ST_SAMPLE: begin
        if (w_sample_last) w_next_state = ST_EVAL;
        else               w_next_state = ST_SAMPLE;
      end
      ST_EVAL: begin
        if (!w_acc_done)                                    w_next_state = ST_EVAL;
        else if (r_prev_valid && !r_prev_vote && w_acc_vote) w_next_state = ST_DONE;
        else if (r_oor_seen || w_tap_last)                  w_next_state = ST_FAIL_LOAD;
        else                                                w_next_state = ST_STEP;
      end
      ST_STEP:      w_next_state = ST_SETTLE;
      ST_FAIL_LOAD: w_next_state = ST_FAIL;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  // State register and outputs registered from the next state.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_load  <= 1'b0;
      r_move  <= 1'b0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_load  <= (w_next_state == ST_LOAD) || (w_next_state == ST_FAIL_LOAD);
      r_move  <= (w_next_state == ST_STEP);
      r_dir   <= (w_next_state == ST_STEP);
      r_busy  <= !((w_next_state == ST_IDLE) || (w_next_state == ST_DONE) ||
                   (w_next_state == ST_FAIL));
      r_done  <= (w_next_state == ST_DONE);
      r_fail  <= (w_next_state == ST_FAIL);
    end
  end

  // Sweep bookkeeping: settle timer, tap count, previous vote and sticky out-of-range.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      r_settle_cnt <= '0;
      r_tap_cnt    <= '0;
      r_prev_valid <= 1'b0;
      r_prev_vote  <= 1'b0;
      r_oor_seen   <= 1'b0;
    end else begin
      if ((r_state == ST_SETTLE) && !w_settle_last) r_settle_cnt <= r_settle_cnt + SET_W'(1);
      else                                          r_settle_cnt <= '0;
      if (w_next_state == ST_LOAD) begin
        r_tap_cnt    <= '0;
        r_prev_valid <= 1'b0;
        r_prev_vote  <= 1'b0;
        r_oor_seen   <= 1'b0;
      end else begin
        if (r_state == ST_STEP) r_tap_cnt <= r_tap_cnt + TAP_W'(1);
        if (((r_state == ST_SETTLE) || (r_state == ST_SAMPLE)) && bus.delay_line_out_of_range)
          r_oor_seen <= 1'b1;
        if ((r_state == ST_EVAL) && w_acc_done) begin
          r_prev_vote  <= w_acc_vote;
          r_prev_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.delay_line_load = r_load;
  assign bus.delay_line_move = r_move;
  assign bus.delay_line_dir  = r_dir;
  assign bus.busy            = r_busy;
  assign bus.align_done      = r_done;
  assign bus.align_fail      = r_fail;
  assign bus.edge_tap        = r_tap_cnt;

endmodule

// File: tb/tb_delay_line_align_ctrl.sv
// Self-checking bench: delay-line model, pulse scoreboard, vector table and corner sequences.
module tb_delay_line_align_ctrl;
  import delay_line_align_pkg::*;

  localparam int SETTLE = int'(SETTLE_CYCLES_DEF);
  localparam int VOTE   = int'(VOTE_SAMPLES_DEF);
  localparam int STEP   = int'(SWEEP_STEP_CYCLES);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  delay_line_align_if #(.TAP_W(8)) bus ();

  delay_line_align_ctrl #(
    .TAP_W(8), .MAX_TAPS(128), .SETTLE_CYCLES(SETTLE_CYCLES_DEF), .VOTE_SAMPLES(VOTE_SAMPLES_DEF)
  ) dut (
    .i_sclk  (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Delay line environment model.
  int   tb_tap = 0;
  int   since  = 0;
  int   thr    = 1000;
  bit   pat_mode = 1'b0;
  bit   oor_en   = 1'b0;
  int   oor_tap  = 0;
  logic [3:0] pat [0:2];
  int   ph_idx;

  always @(posedge clk) begin
    if (bus.delay_line_load) begin
      tb_tap <= 0;
      since  <= 0;
    end else if (bus.delay_line_move && bus.delay_line_dir) begin
      tb_tap <= tb_tap + 1;
      since  <= 0;
    end else begin
      since <= since + 1;
    end
  end

  always_comb begin
    ph_idx = since - SETTLE;
    if (pat_mode)
      bus.phase_in = (tb_tap < 3 && ph_idx >= 0 && ph_idx < VOTE) ? pat[tb_tap][ph_idx] : 1'b0;
    else
      bus.phase_in = (tb_tap >= thr);
  end

  assign bus.delay_line_out_of_range = oor_en && (tb_tap == oor_tap);

  // Pulse scoreboard.
  typedef struct packed { bit is_load; bit gap_chk; } ev_t;
  ev_t exp_q[$];
  int  cyc = 0;
  int  last_pulse = 0;
  int  n_load = 0;
  int  n_move = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    chk("dir_eq_move", bus.delay_line_dir, bus.delay_line_move);
    if (bus.delay_line_load || bus.delay_line_move) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {bus.delay_line_load, bus.delay_line_move}, 2'b00);
      end else begin
        chk("pulse_kind", {bus.delay_line_load, bus.delay_line_move},
            exp_q[0].is_load ? 2'b10 : 2'b01);
        if (exp_q[0].gap_chk) chk("pulse_gap", cyc - last_pulse, STEP);
        exp_q.delete(0);
      end
      last_pulse <= cyc;
      if (bus.delay_line_load) n_load <= n_load + 1;
      if (bus.delay_line_move) n_move <= n_move + 1;
    end
  end

  task automatic run_align(input string tag, input int exp_done, input int exp_fail,
                           input int exp_tap, input int exp_moves, input bit hold_busy);
    exp_q.push_back('{is_load: 1'b1, gap_chk: 1'b0});
    for (int m = 0; m < exp_moves; m++) exp_q.push_back('{is_load: 1'b0, gap_chk: 1'b1});
    if (exp_fail != 0) exp_q.push_back('{is_load: 1'b1, gap_chk: 1'b1});
    n_load = 0;
    n_move = 0;
    @(posedge clk); #1;
    bus.align_start = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_load_latency"}, bus.delay_line_load, 1'b1);
    chk({tag, "_busy_at_load"}, bus.busy, 1'b1);
    chk({tag, "_tap_at_load"}, bus.edge_tap, 0);
    bus.align_start = 1'b0;
    if (hold_busy) begin
      repeat (5) @(posedge clk);
      #1 bus.align_start = 1'b1;
      repeat (20) @(posedge clk);
      #1 bus.align_start = 1'b0;
    end
    for (int i = 0; i < 3000 && !(bus.align_done || bus.align_fail); i++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_finished"}, bus.align_done | bus.align_fail, 1'b1);
    chk({tag, "_done"}, bus.align_done, exp_done);
    chk({tag, "_fail"}, bus.align_fail, exp_fail);
    chk({tag, "_edge_tap"}, bus.edge_tap, exp_tap);
    chk({tag, "_busy_end"}, bus.busy, 1'b0);
    chk({tag, "_moves"}, n_move, exp_moves);
    chk({tag, "_loads"}, n_load, 1 + exp_fail);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    repeat (3) @(posedge clk); #1;
    chk({tag, "_tap_frozen"}, bus.edge_tap, exp_tap);
  endtask

  typedef struct {
    int thr; bit oor_en; int oor_tap;
    int exp_done; int exp_fail; int exp_tap; int exp_moves;
  } vec_t;
  vec_t vecs [0:5];

  initial begin
    vecs[0] = '{5,    1'b0, 0, 1, 0, 5,   5};
    vecs[1] = '{0,    1'b0, 0, 0, 1, 127, 127};
    vecs[2] = '{1000, 1'b1, 3, 0, 1, 3,   3};
    vecs[3] = '{1,    1'b0, 0, 1, 0, 1,   1};
    vecs[4] = '{127,  1'b0, 0, 1, 0, 127, 127};
    vecs[5] = '{1000, 1'b0, 0, 0, 1, 127, 127};
    pat[0] = 4'b0001;
    pat[1] = 4'b0011;
    pat[2] = 4'b1011;
    bus.align_start = 1'b0;

    // Reset values and quiet period.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_load", bus.delay_line_load, 1'b0);
    chk("rst_move", bus.delay_line_move, 1'b0);
    chk("rst_dir", bus.delay_line_dir, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.align_done, 1'b0);
    chk("rst_fail", bus.align_fail, 1'b0);
    chk("rst_tap", bus.edge_tap, 0);
    rst = 1'b0;
    n_load = 0;
    n_move = 0;
    repeat (20) @(posedge clk);
    #1 chk("quiet_pulses", n_load + n_move, 0);

    for (int v = 0; v < 6; v++) begin
      thr     = vecs[v].thr;
      oor_en  = vecs[v].oor_en;
      oor_tap = vecs[v].oor_tap;
      run_align($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_fail,
                vecs[v].exp_tap, vecs[v].exp_moves, 1'b0);
      oor_en = 1'b0;
    end

    // Vote boundary: 1-of-4 and a tie vote 0, 3-of-4 votes 1.
    pat_mode = 1'b1;
    run_align("vote", 1, 0, 2, 2, 1'b0);
    pat_mode = 1'b0;

    // Reset mid-sweep at tap 10, then a clean restart that ignores START while busy.
    thr = 1000;
    exp_q.push_back('{is_load: 1'b1, gap_chk: 1'b0});
    for (int m = 0; m < 10; m++) exp_q.push_back('{is_load: 1'b0, gap_chk: 1'b1});
    @(posedge clk); #1 bus.align_start = 1'b1;
    @(posedge clk); #1 bus.align_start = 1'b0;
    for (int i = 0; i < 500 && tb_tap != 10; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_reached_tap10", tb_tap, 10);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_load", bus.delay_line_load, 1'b0);
    chk("mid_rst_move", bus.delay_line_move, 1'b0);
    chk("mid_rst_dir", bus.delay_line_dir, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_done", bus.align_done, 1'b0);
    chk("mid_rst_fail", bus.align_fail, 1'b0);
    chk("mid_rst_tap", bus.edge_tap, 0);
    chk("mid_rst_queue", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    thr = 3;
    run_align("restart", 1, 0, 3, 3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
